ct_spsram_512x144_ctrl: RTL

- Controller and arbiter for one 512x144 single-port SRAM (A/CEN/GWEN/WEN/D/Q, active-low controls, 1-cycle read latency).
- Shares the macro between two requesters using round-robin arbitration.
- Returns read data tagged with the requester ID.
- Runs a zero-fill sweep of all 512 entries after reset and on demand.

---
 rtl/ct_spsram_512x144_ctrl_if.sv | 37 +++
 rtl/ct_spsram_512x144_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ct_spsram_512x144_ctrl_if.sv
// Requester bundle for the 512x144 SRAM controller: two valid/gnt ports.
// The master side drives the request fields; the slave side returns the grants.
interface ct_spsram_512x144_ctrl_if #(
  parameter int AW = 9,
  parameter int DW = 144
);
  logic          req0_vld;
  logic          req0_wr;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_din;
  logic [DW-1:0] req0_bmask;
  logic          req0_gnt;
  logic          req1_vld;
  logic          req1_wr;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_din;
  logic [DW-1:0] req1_bmask;
  logic          req1_gnt;

  modport master (
    output req0_vld, req0_wr, req0_addr,
    output req0_din, req0_bmask,
    input  req0_gnt,
    output req1_vld, req1_wr, req1_addr,
    output req1_din, req1_bmask,
    input  req1_gnt
  );

  modport slave (
    input  req0_vld, req0_wr, req0_addr,
    input  req0_din, req0_bmask,
    output req0_gnt,
    input  req1_vld, req1_wr, req1_addr,
    input  req1_din, req1_bmask,
    output req1_gnt
  );
endinterface

// File: rtl/ct_spsram_512x144_ctrl.sv
// Round-robin controller for one 512x144 single-port SRAM.
// Define CT_SPSRAM_512X144_CTRL_INIT_EN to build the zero-fill init sweep.
module ct_spsram_512x144_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 144,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  output logic                  init_done,
  ct_spsram_512x144_ctrl_if.slave req,
  output logic                  rd_vld,
  output logic                  rd_id,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_nxt;
  logic                  r_rr;
  logic                  r_rd_vld;
  logic                  r_rd_id;
  logic [ADDR_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_d;
  logic                  w_run;
  logic                  w_init;
  logic [ADDR_WIDTH-1:0] w_cnt;
  logic                  w_g0;
  logic                  w_g1;

`ifdef CT_SPSRAM_512X144_CTRL_INIT_EN
  logic [ADDR_WIDTH-1:0] r_init_cnt;

  // Counter wraps 511 -> 0 on the last sweep write.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)
      r_init_cnt <= '0;
    else if (w_init)
      r_init_cnt <= r_init_cnt + 1'b1;
  end

  assign w_init = (r_state == S_INIT);
  assign w_cnt  = r_init_cnt;
`else
  logic w_unused;
  assign w_unused = init_req;
  assign w_init   = 1'b0;
  assign w_cnt    = '0;
`endif

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)
      r_state <= S_IDLE;
    else
      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
`ifdef CT_SPSRAM_512X144_CTRL_INIT_EN
      S_IDLE: w_nxt = S_INIT;
      S_INIT: if (&r_init_cnt) w_nxt = S_RUN;
      S_RUN:  if (init_req) w_nxt = S_INIT;
`else
      S_IDLE: w_nxt = S_RUN;
      S_RUN:  w_nxt = S_RUN;
`endif
      default: w_nxt = S_IDLE;
    endcase
  end

  assign w_run = (r_state == S_RUN);
  assign w_g0  = w_run & req.req0_vld &
                 (~req.req1_vld | r_rr);
  assign w_g1  = w_run & req.req1_vld &
                 (~req.req0_vld | ~r_rr);

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = r_a;
    sram_d    = r_d;
    unique case (1'b1)
      w_init: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = w_cnt;
        sram_d    = INIT_DATA;
      end
      w_g0: begin
        sram_cen = 1'b0;
        sram_a   = req.req0_addr;
        if (req.req0_wr) begin
          sram_gwen = 1'b0;
          sram_wen  = ~req.req0_bmask;
          sram_d    = req.req0_din;
        end
      end
      w_g1: begin
        sram_cen = 1'b0;
        sram_a   = req.req1_addr;
        if (req.req1_wr) begin
          sram_gwen = 1'b0;
          sram_wen  = ~req.req1_bmask;
          sram_d    = req.req1_din;
        end
      end
      default: ;
    endcase
  end

  // Address/data pins keep their last value when idle.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_a      <= '0;
      r_d      <= '0;
      r_rr     <= 1'b1;
      r_rd_vld <= 1'b0;
      r_rd_id  <= 1'b0;
    end else begin
      r_a      <= sram_a;
      r_d      <= sram_d;
      r_rd_vld <= (w_g0 & ~req.req0_wr) |
                  (w_g1 & ~req.req1_wr);
      if (w_g0)
        r_rr <= 1'b0;
      else if (w_g1)
        r_rr <= 1'b1;
      if (w_g0 & ~req.req0_wr)
        r_rd_id <= 1'b0;
      else if (w_g1 & ~req.req1_wr)
        r_rd_id <= 1'b1;
    end
  end

  assign req.req0_gnt = w_g0;
  assign req.req1_gnt = w_g1;
  assign init_done    = w_run;
  assign rd_vld       = r_rd_vld;
  assign rd_id        = r_rd_id;
  assign rd_data      = sram_q;

endmodule
